// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter and its helpers.
// Optional feature macro used by the top: SEG_ARB_BLINK_EN.
package seg_disp_pkg;

    localparam int DISP_W = 32;
    localparam int DIGITS = 8;

    localparam logic [7:0] DISP_ALL_ON  = 8'hFF;
    localparam logic [7:0] DISP_ALL_OFF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_SHARE = 2'd2,
        ST_ARB   = 2'd3
    } arb_state_e;

    // Clock cycles per 1 ms tick; never below one so tiny test clocks still tick.
    function automatic int ms_tick_div(input int clk_freq_hz);
        int div_v;
        div_v = clk_freq_hz / 1000;
        if (div_v < 1) begin
            div_v = 1;
        end else begin
            div_v = div_v;
        end
        return div_v;
    endfunction

endpackage

// File: rtl/seg_ms_tick.sv
// Free-running millisecond tick generator: one-cycle Tick at the terminal count of a
// 0..DIV-1 counter. Shared by the display blocks.
module seg_ms_tick #(
    parameter int DIV = 50000
) (
    input  logic Clk,
    input  logic Reset,
    output logic Tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the terminal value.
    always_comb begin
        if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = (cnt_q == TERM);

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing the 8-digit scanner's display word between N_REQ requesters,
// with minimum hold and contended timeout. Blink support is built when SEG_ARB_BLINK_EN is defined.
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter int          CLK_FREQ_HZ  = 50_000_000,
    parameter int          HOLD_MS      = 500,
    parameter int          TIMEOUT_MS   = 2000,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000,
    parameter int          BLINK_MS     = 250
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        Req,
    input  logic [DISP_W*N_REQ-1:0] Req_Data,
    output logic [N_REQ-1:0]        Gnt,
    output logic [DISP_W-1:0]       Disp_Data,
    output logic                    Disp_Valid,
    output logic [DIGITS-1:0]       Disp_En
`ifdef SEG_ARB_BLINK_EN
    ,
    input  logic [N_REQ-1:0]        Blink
`endif
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM    = HOLD_W'(HOLD_MS);
    localparam logic [HOLD_W-1:0] TIMEOUT_LIM = HOLD_W'(TIMEOUT_MS);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    if (N_REQ < 2 || N_REQ > 8 || HOLD_MS < 1 || HOLD_MS > TIMEOUT_MS || BLINK_MS < 1) begin : g_bad_param
        $error("seg_disp_arbiter: illegal parameter combination");
    end

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DISP_W-1:0]  disp_data_q, disp_data_d;
    logic               disp_valid_q, disp_valid_d;
    logic [DIGITS-1:0]  disp_en_q, disp_en_d;

    logic               tick_s;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [IDX_W-1:0]   win_next_s;
    logic               owner_req_s;
    logic               others_req_s;
    logic [DISP_W-1:0]  owner_slice_s;
    logic [DISP_W-1:0]  win_slice_s;
    logic               held_s;

    seg_ms_tick #(
        .DIV (ms_tick_div(CLK_FREQ_HZ))
    ) u_ms_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .Tick  (tick_s)
    );

    // Round-robin search starting at the pointer, which sits one past the last owner.
    always_comb begin
        int cand_v;
        cand_v      = 0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_v = (int'(rr_ptr_q) + i) % N_REQ;
            if (!win_found_s && Req[cand_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand_v);
            end else begin
                win_found_s = win_found_s;
            end
        end
        if (int'(win_idx_s) == N_REQ - 1) begin
            win_next_s = '0;
        end else begin
            win_next_s = win_idx_s + IDX_W'(1);
        end
    end

    assign owner_req_s   = Req[owner_q];
    assign others_req_s  = |(Req & ~gnt_q);
    assign owner_slice_s = Req_Data[int'(owner_q)*DISP_W +: DISP_W];
    assign win_slice_s   = Req_Data[int'(win_idx_s)*DISP_W +: DISP_W];

    // FSM next-state, hold counter and data path.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        hold_d       = hold_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        case (state_q)
            ST_IDLE, ST_ARB: begin
                if (win_found_s) begin
                    state_d      = ST_OWN;
                    gnt_d        = N_REQ'(1) << win_idx_s;
                    owner_d      = win_idx_s;
                    rr_ptr_d     = win_next_s;
                    hold_d       = '0;
                    disp_data_d  = win_slice_s;
                    disp_valid_d = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    disp_data_d  = DEFAULT_DATA;
                    disp_valid_d = 1'b0;
                end
            end
            ST_OWN: begin
                if (owner_req_s) begin
                    disp_data_d = owner_slice_s;
                end else begin
                    disp_data_d = disp_data_q;
                end
                // OWN is exactly the region hold < HOLD_MS, so switch as the count arrives.
                if (tick_s) begin
                    hold_d = hold_q + HOLD_ONE;
                    if ((hold_q + HOLD_ONE) == HOLD_LIM) begin
                        state_d = ST_SHARE;
                    end else begin
                        state_d = ST_OWN;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            ST_SHARE: begin
                if (!owner_req_s || ((hold_q >= TIMEOUT_LIM) && others_req_s)) begin
                    state_d      = ST_ARB;
                    gnt_d        = '0;
                    disp_valid_d = 1'b0;
                end else begin
                    state_d     = ST_SHARE;
                    disp_data_d = owner_slice_s;
                    if (tick_s && (hold_q < TIMEOUT_LIM)) begin
                        hold_d = hold_q + HOLD_ONE;
                    end else begin
                        hold_d = hold_q;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                gnt_d        = '0;
                disp_data_d  = DEFAULT_DATA;
                disp_valid_d = 1'b0;
            end
        endcase
    end

    assign held_s = ((state_q == ST_OWN) || (state_q == ST_SHARE)) &&
                    ((state_d == ST_OWN) || (state_d == ST_SHARE));

`ifdef SEG_ARB_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_MS + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Blink phase: restart lit on every grant, release or Blink drop.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (held_s && Blink[owner_q]) begin
            if (tick_s) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_off_d = ~blink_off_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end else begin
                blink_cnt_d = blink_cnt_q;
            end
        end else begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end
        if (blink_off_d) begin
            disp_en_d = DISP_ALL_OFF;
        end else begin
            disp_en_d = DISP_ALL_ON;
        end
    end

    // Blink phase registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    // Without blink support every digit stays enabled.
    always_comb begin
        disp_en_d = DISP_ALL_ON;
    end
`endif

    // FSM state, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            hold_q       <= '0;
            disp_data_q  <= DEFAULT_DATA;
            disp_valid_q <= 1'b0;
            disp_en_q    <= DISP_ALL_ON;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_q       <= hold_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            disp_en_q    <= disp_en_d;
        end
    end

    assign Gnt        = gnt_q;
    assign Disp_Data  = disp_data_q;
    assign Disp_Valid = disp_valid_q;
    assign Disp_En    = disp_en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter: 10 cycles per ms tick, HOLD_MS=3, TIMEOUT_MS=6, N_REQ=4.
module tb_seg_disp_arbiter;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [3:0]   Req = 4'b0000;
    logic [127:0] Req_Data = 128'h0;
    logic [3:0]   Blink = 4'b0000;
    logic [3:0]   Gnt;
    logic [31:0]  Disp_Data;
    logic         Disp_Valid;
    logic [7:0]   Disp_En;

    int compared = 0;
    int mismatched = 0;
    int edge_n = 0;

    seg_disp_arbiter #(
        .N_REQ        (4),
        .CLK_FREQ_HZ  (10_000),
        .HOLD_MS      (3),
        .TIMEOUT_MS   (6),
        .DEFAULT_DATA (32'h0000_0000),
        .BLINK_MS     (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Req_Data   (Req_Data),
        .Gnt        (Gnt),
        .Disp_Data  (Disp_Data),
        .Disp_Valid (Disp_Valid),
        .Disp_En    (Disp_En)
`ifdef SEG_ARB_BLINK_EN
        ,
        .Blink      (Blink)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
        edge_n++;
    endtask

    task automatic go_to(input int e);
        while (edge_n < e) step();
    endtask

    // Two reset edges; the second one is edge 0 of the following test.
    task automatic do_reset();
        Reset = 1'b1;
        Req   = 4'b0000;
        Blink = 4'b0000;
        step();
        step();
        edge_n = 0;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL reset_gnt: got %b want %b", Gnt, 4'b0000); end
        compared++; if (Disp_Data !== 32'h0000_0000) begin mismatched++; $display("FAIL reset_data: got %h want %h", Disp_Data, 32'h0000_0000); end
        compared++; if (Disp_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want %b", Disp_Valid, 1'b0); end
        compared++; if (Disp_En !== 8'hFF) begin mismatched++; $display("FAIL reset_en: got %h want %h", Disp_En, 8'hFF); end
    endtask

    task automatic test_single_request();
        do_reset();
        Req_Data = 128'h0;
        Req_Data[0 +: 32]  = 32'hAAAA_0000;
        Req_Data[32 +: 32] = 32'h1234_5678;
        Req = 4'b0010;
        go_to(1);
        compared++; if (Gnt !== 4'b0010) begin mismatched++; $display("FAIL single_gnt: got %b want %b", Gnt, 4'b0010); end
        compared++; if (Disp_Data !== 32'h1234_5678) begin mismatched++; $display("FAIL single_data: got %h want %h", Disp_Data, 32'h1234_5678); end
        compared++; if (Disp_Valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want %b", Disp_Valid, 1'b1); end
        Req_Data[32 +: 32] = 32'h0BAD_F00D;
        go_to(2);
        compared++; if (Disp_Data !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL single_follow: got %h want %h", Disp_Data, 32'h0BAD_F00D); end
        go_to(5);
        Req = 4'b0000;
        Req_Data[32 +: 32] = 32'hDEAD_BEEF;
        go_to(6);
        compared++; if (Disp_Data !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL single_freeze: got %h want %h", Disp_Data, 32'h0BAD_F00D); end
        compared++; if (Gnt !== 4'b0010) begin mismatched++; $display("FAIL single_no_release: got %b want %b", Gnt, 4'b0010); end
        go_to(30);
        compared++; if (Gnt !== 4'b0010) begin mismatched++; $display("FAIL single_hold_end: got %b want %b", Gnt, 4'b0010); end
        go_to(31);
        compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL single_arb_gnt: got %b want %b", Gnt, 4'b0000); end
        compared++; if (Disp_Valid !== 1'b0) begin mismatched++; $display("FAIL single_arb_valid: got %b want %b", Disp_Valid, 1'b0); end
        compared++; if (Disp_Data !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL single_arb_data: got %h want %h", Disp_Data, 32'h0BAD_F00D); end
        go_to(32);
        compared++; if (Disp_Data !== 32'h0000_0000) begin mismatched++; $display("FAIL single_idle_data: got %h want %h", Disp_Data, 32'h0000_0000); end
        compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL single_idle_gnt: got %b want %b", Gnt, 4'b0000); end
    endtask

    task automatic test_contention();
        int          gnt_edge [4];
        logic [3:0]  exp_gnt  [4];
        logic [31:0] exp_data [4];
        gnt_edge = '{1, 62, 122, 182};
        exp_gnt  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_data = '{32'h0000_A000, 32'h1111_B111, 32'h3333_D333, 32'h0000_A000};
        do_reset();
        Req_Data = {32'h3333_D333, 32'h2222_C222, 32'h1111_B111, 32'h0000_A000};
        Req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                go_to(gnt_edge[k] - 1);
                compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL contend_gap%0d: got %b want %b", k, Gnt, 4'b0000); end
            end
            go_to(gnt_edge[k]);
            compared++; if (Gnt !== exp_gnt[k]) begin mismatched++; $display("FAIL contend_gnt%0d: got %b want %b", k, Gnt, exp_gnt[k]); end
            compared++; if (Disp_Data !== exp_data[k]) begin mismatched++; $display("FAIL contend_data%0d: got %h want %h", k, Disp_Data, exp_data[k]); end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        Req_Data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0F00};
        Req = 4'b0100;
        go_to(1);
        compared++; if (Gnt !== 4'b0100) begin mismatched++; $display("FAIL early_gnt2: got %b want %b", Gnt, 4'b0100); end
        go_to(5);
        Req = 4'b0101;
        go_to(40);
        compared++; if (Gnt !== 4'b0100) begin mismatched++; $display("FAIL early_hold4: got %b want %b", Gnt, 4'b0100); end
        Req = 4'b0001;
        go_to(41);
        compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL early_arb: got %b want %b", Gnt, 4'b0000); end
        go_to(42);
        compared++; if (Gnt !== 4'b0001) begin mismatched++; $display("FAIL early_gnt0: got %b want %b", Gnt, 4'b0001); end
        compared++; if (Disp_Data !== 32'h0000_0F00) begin mismatched++; $display("FAIL early_data0: got %h want %h", Disp_Data, 32'h0000_0F00); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        Req_Data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0505};
        Req = 4'b1000;
        go_to(35);
        compared++; if (Gnt !== 4'b1000) begin mismatched++; $display("FAIL midrst_share: got %b want %b", Gnt, 4'b1000); end
        Reset = 1'b1;
        Req = 4'b1001;
        go_to(36);
        compared++; if (Gnt !== 4'b0000) begin mismatched++; $display("FAIL midrst_gnt: got %b want %b", Gnt, 4'b0000); end
        compared++; if (Disp_Data !== 32'h0000_0000) begin mismatched++; $display("FAIL midrst_data: got %h want %h", Disp_Data, 32'h0000_0000); end
        compared++; if (Disp_Valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b want %b", Disp_Valid, 1'b0); end
        compared++; if (Disp_En !== 8'hFF) begin mismatched++; $display("FAIL midrst_en: got %h want %h", Disp_En, 8'hFF); end
        Reset = 1'b0;
        go_to(37);
        compared++; if (Gnt !== 4'b0001) begin mismatched++; $display("FAIL midrst_first: got %b want %b", Gnt, 4'b0001); end
        compared++; if (Disp_Data !== 32'h0000_0505) begin mismatched++; $display("FAIL midrst_first_data: got %h want %h", Disp_Data, 32'h0000_0505); end
    endtask

`ifdef SEG_ARB_BLINK_EN
    task automatic test_blink();
        do_reset();
        Req_Data = 128'h0;
        Req = 4'b0001;
        Blink = 4'b0001;
        go_to(19);
        compared++; if (Disp_En !== 8'hFF) begin mismatched++; $display("FAIL blink_on1: got %h want %h", Disp_En, 8'hFF); end
        go_to(20);
        compared++; if (Disp_En !== 8'h00) begin mismatched++; $display("FAIL blink_off1: got %h want %h", Disp_En, 8'h00); end
        go_to(39);
        compared++; if (Disp_En !== 8'h00) begin mismatched++; $display("FAIL blink_off_end: got %h want %h", Disp_En, 8'h00); end
        go_to(40);
        compared++; if (Disp_En !== 8'hFF) begin mismatched++; $display("FAIL blink_on2: got %h want %h", Disp_En, 8'hFF); end
        go_to(61);
        compared++; if (Disp_En !== 8'h00) begin mismatched++; $display("FAIL blink_off2: got %h want %h", Disp_En, 8'h00); end
        Blink = 4'b0000;
        go_to(62);
        compared++; if (Disp_En !== 8'hFF) begin mismatched++; $display("FAIL blink_drop: got %h want %h", Disp_En, 8'hFF); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_request();
        test_contention();
        test_early_release();
        test_reset_mid_grant();
`ifdef SEG_ARB_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
